// File: rtl/spi_frame_master_if.sv
// Host and SPI pin bundle for spi_frame_master.
// The DUT uses the master modport; the driving host or bench side uses slave.
interface spi_frame_master_if;
  logic       start;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       cs_n;

  modport master (
    input  start, addr, wdata, miso,
    output busy, done, rdata, sclk, mosi, cs_n
  );

  modport slave (
    output start, addr, wdata, miso,
    input  busy, done, rdata, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_frame_master.sv
// SPI mode-0 master that writes one {addr,wdata} 16-bit frame per start request.
// Optional miso capture of the data byte is enabled by SPI_FRAME_MASTER_READBACK_EN.
module spi_frame_master #(
  parameter int CLK_DIV = 2
) (
  input logic                clk,
  input logic                rst_n,
  spi_frame_master_if.master bus
);

  localparam int               DIV_W    = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_r, state_d;
  logic [DIV_W-1:0] div_r, div_d;
  logic [4:0]       bit_r, bit_d;
  logic [15:0]      shift_r, shift_d;
  logic             sclk_r, sclk_d;
  logic             cs_n_r, cs_n_d;
  logic             busy_r, busy_d;
  logic             done_r, done_d;
  logic             div_end_s;

`ifdef SPI_FRAME_MASTER_READBACK_EN
  logic             sample_s;
  logic             load_s;
  logic [7:0]       rx_r;
  logic [7:0]       rdata_r;
`endif

  assign div_end_s = (div_r == DIV_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_d;
    end
  end

  // Next-state, counter and next-output decode; outputs are registered below
  always_comb begin
    state_d = state_r;
    div_d   = div_r;
    bit_d   = bit_r;
    shift_d = shift_r;
    sclk_d  = sclk_r;
    cs_n_d  = cs_n_r;
    busy_d  = busy_r;
    done_d  = 1'b0;
`ifdef SPI_FRAME_MASTER_READBACK_EN
    sample_s = 1'b0;
    load_s   = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        sclk_d = 1'b0;
        cs_n_d = 1'b1;
        busy_d = 1'b0;
        if (bus.start) begin
          state_d = SETUP;
          shift_d = {bus.addr, bus.wdata};
          div_d   = DIV_ZERO;
          bit_d   = 5'd0;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (div_end_s) begin
          state_d = SHIFT;
          div_d   = DIV_ZERO;
        end else begin
          div_d = div_r + DIV_ONE;
        end
      end
      SHIFT: begin
        if (div_end_s) begin
          div_d = DIV_ZERO;
          if (!sclk_r) begin
            sclk_d = 1'b1;
`ifdef SPI_FRAME_MASTER_READBACK_EN
            // bit_r[3] marks the data byte (bits 8..15)
            sample_s = bit_r[3];
`endif
          end else begin
            // mosi advances only here, on the falling sclk edge
            sclk_d  = 1'b0;
            shift_d = {shift_r[14:0], 1'b0};
            if (bit_r == 5'd15) begin
              state_d = HOLD;
            end else begin
              bit_d = bit_r + 5'd1;
            end
          end
        end else begin
          div_d = div_r + DIV_ONE;
        end
      end
      HOLD: begin
        if (div_end_s) begin
          state_d = DONE;
          div_d   = DIV_ZERO;
          bit_d   = 5'd0;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
`ifdef SPI_FRAME_MASTER_READBACK_EN
          load_s  = 1'b1;
`endif
        end else begin
          div_d = div_r + DIV_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        sclk_d  = 1'b0;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Datapath and registered SPI/handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_r   <= DIV_ZERO;
      bit_r   <= 5'd0;
      shift_r <= 16'h0000;
      sclk_r  <= 1'b0;
      cs_n_r  <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      div_r   <= div_d;
      bit_r   <= bit_d;
      shift_r <= shift_d;
      sclk_r  <= sclk_d;
      cs_n_r  <= cs_n_d;
      busy_r  <= busy_d;
      done_r  <= done_d;
    end
  end

`ifdef SPI_FRAME_MASTER_READBACK_EN
  // Data-byte capture from miso, published on the DONE cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_r    <= 8'h00;
      rdata_r <= 8'h00;
    end else begin
      if (sample_s) begin
        rx_r <= {rx_r[6:0], bus.miso};
      end
      if (load_s) begin
        rdata_r <= rx_r;
      end
    end
  end

  assign bus.rdata = rdata_r;
`else
  assign bus.rdata = 8'h00;
`endif

  assign bus.sclk = sclk_r;
  assign bus.mosi = shift_r[15];
  assign bus.cs_n = cs_n_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_spi_frame_master.sv
// Randomized self-checking bench: three DUTs (CLK_DIV 2, 1, 255) against a
// timeline model of each frame plus a miso slave that answers per sclk edge.
module tb_spi_frame_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [2:0]      start_v, miso_v, busy_v, done_v, sclk_v, mosi_v, cs_n_v;
  logic [2:0][7:0] addr_v, wdata_v, rdata_v;

`ifdef SPI_FRAME_MASTER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  for (genvar g = 0; g < 3; g++) begin : lane
    spi_frame_master_if bus ();
    assign bus.start  = start_v[g];
    assign bus.addr   = addr_v[g];
    assign bus.wdata  = wdata_v[g];
    assign bus.miso   = miso_v[g];
    assign busy_v[g]  = bus.busy;
    assign done_v[g]  = bus.done;
    assign rdata_v[g] = bus.rdata;
    assign sclk_v[g]  = bus.sclk;
    assign mosi_v[g]  = bus.mosi;
    assign cs_n_v[g]  = bus.cs_n;
    spi_frame_master #(.CLK_DIV((g == 0) ? 2 : ((g == 1) ? 1 : 255))) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
    );
  end

  function automatic int div_of(input int l);
    return (l == 0) ? 2 : ((l == 1) ? 1 : 255);
  endfunction

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;
  bit force_3c = 1'b0;

  task automatic check(input string nm, input int l, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane %0d cyc %0d got %h want %h", nm, l, cyc, act, exp);
    end
  endtask

  // Model: a frame is a timeline t = edges since acceptance; 34*D is the done cycle
  bit          m_act   [3] = '{1'b0, 1'b0, 1'b0};
  int          m_t     [3] = '{0, 0, 0};
  logic [15:0] m_frame [3];
  logic [7:0]  m_resp  [3] = '{8'h00, 8'h00, 8'h00};
  logic [7:0]  m_rdata [3] = '{8'h00, 8'h00, 8'h00};

  always @(posedge clk) begin
    cyc++;
    for (int l = 0; l < 3; l++) begin
      if (!rst_n) begin
        m_act[l]   = 1'b0;
        m_rdata[l] = 8'h00;
      end else if (!m_act[l]) begin
        if (start_v[l]) begin
          m_act[l]   = 1'b1;
          m_t[l]     = 0;
          m_frame[l] = {addr_v[l], wdata_v[l]};
          m_resp[l]  = force_3c ? 8'h3C : 8'($urandom);
        end
      end else begin
        m_t[l]++;
        if (m_t[l] == 34 * div_of(l)) m_rdata[l] = RB ? m_resp[l] : 8'h00;
        else if (m_t[l] > 34 * div_of(l)) m_act[l] = 1'b0;
      end
    end
  end

  // Compare every output of every lane against the model each cycle
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int l = 0; l < 3; l++) begin
        int d, t, b;
        bit e_cs_n, e_busy, e_done, e_sclk;
        d = div_of(l);
        t = m_t[l];
        e_cs_n = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_sclk = 1'b0;
        if (m_act[l]) begin
          e_cs_n = (t >= 34 * d);
          e_busy = 1'b1;
          e_done = (t == 34 * d);
          e_sclk = (t >= d && t < 33 * d) ? (((t - d) / d) % 2 == 1) : 1'b0;
          if (t < 33 * d) begin
            b = (t < d) ? 0 : (t - d) / (2 * d);
            check("mosi", l, mosi_v[l], m_frame[l][15 - b]);
          end
        end
        check("cs_n", l, cs_n_v[l], e_cs_n);
        check("busy", l, busy_v[l], e_busy);
        check("done", l, done_v[l], e_done);
        check("sclk", l, sclk_v[l], e_sclk);
        check("rdata", l, rdata_v[l], m_rdata[l]);
      end
    end
  end

  // miso slave: presents response bit n while n sclk rises have been seen
  int   s_cnt  [3] = '{0, 0, 0};
  logic s_prev [3] = '{1'b0, 1'b0, 1'b0};
  always @(negedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (cs_n_v[l] !== 1'b0) s_cnt[l] = 0;
      else if (sclk_v[l] && !s_prev[l]) s_cnt[l]++;
      s_prev[l] = sclk_v[l];
      miso_v[l] = (s_cnt[l] >= 8 && s_cnt[l] < 16) ? m_resp[l][15 - s_cnt[l]] : 1'($urandom);
    end
  end

  // mosi as seen on lane 0 sclk rising edges
  logic [15:0] cap0 = 16'h0000;
  logic cap_ps = 1'b0, cap_pc = 1'b1;
  always @(negedge clk) begin
    if (cap_pc && !cs_n_v[0]) cap0 = 16'h0000;
    else if (sclk_v[0] && !cap_ps) cap0 = {cap0[14:0], mosi_v[0]};
    cap_ps = sclk_v[0];
    cap_pc = cs_n_v[0];
  end

  task automatic wait_done(input int l, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      @(negedge clk);
      if (done_v[l]) at = cyc;
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout lane %0d got none want done within %0d", l, budget);
    end
  endtask

  initial begin
    int acc, at, run, ngaps, ndone;
    bit seen;
    rst_n = 1'b0; start_v = 3'b000; addr_v = '0; wdata_v = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    for (int l = 0; l < 3; l++) begin
      check("rst_cs_n", l, cs_n_v[l], 16'd1);
      check("rst_mosi", l, mosi_v[l], 16'd0);
      check("rst_busy", l, busy_v[l], 16'd0);
      check("rst_rdata", l, rdata_v[l], 16'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed frame 0x05/0xA5 on all lanes, miso answers 0x3C
    addr_v = {3{8'h05}}; wdata_v = {3{8'hA5}}; force_3c = 1'b1; start_v = 3'b111;
    @(negedge clk);
    acc = cyc; start_v = 3'b000; force_3c = 1'b0;
    for (int l = 0; l < 3; l++) begin addr_v[l] = 8'($urandom); wdata_v[l] = 8'($urandom); end
    wait_done(1, 100, at);
    check("lat_div1", 1, 16'(at - acc), 16'd34);
    wait_done(0, 100, at);
    check("lat_div2", 0, 16'(at - acc), 16'd68);
    check("rdata_3c", 0, rdata_v[0], RB ? 16'h003C : 16'h0000);
    @(negedge clk);
    check("busy_after_done", 0, busy_v[0], 16'd0);
    check("mosi_bits", 0, cap0, 16'h05A5);
    wait_done(2, 9000, at);
    check("lat_div255", 2, 16'(at - acc), 16'd8670);
    check("rdata_3c", 2, rdata_v[2], RB ? 16'h003C : 16'h0000);

    // start held high on CLK_DIV=1: cs_n gap between frames
    start_v = 3'b010; run = 0; ngaps = 0; seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (cs_n_v[1]) run++;
      else begin
        if (seen && run != 0) begin check("cs_gap", 1, 16'(run), 16'd2); ngaps++; end
        seen = 1'b1;
        run = 0;
      end
    end
    check("cs_gap_count", 1, 16'(ngaps >= 2), 16'd1);
    start_v = 3'b000;
    repeat (50) @(negedge clk);

    // start and addr changes mid-SHIFT are ignored
    addr_v[0] = 8'($urandom); wdata_v[0] = 8'($urandom); start_v = 3'b001;
    @(negedge clk);
    start_v = 3'b000;
    repeat (20) @(negedge clk);
    start_v = 3'b001; addr_v[0] = ~addr_v[0]; wdata_v[0] = 8'($urandom);
    ndone = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      start_v = 3'b000; addr_v[0] = 8'($urandom);
      if (done_v[0]) ndone++;
    end
    check("single_done", 0, 16'(ndone), 16'd1);

    // reset at the 7th bit, then a clean frame
    start_v = 3'b001;
    @(negedge clk);
    start_v = 3'b000;
    repeat (26) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_cs_n", 0, cs_n_v[0], 16'd1);
    check("abort_sclk", 0, sclk_v[0], 16'd0);
    check("abort_busy", 0, busy_v[0], 16'd0);
    check("abort_done", 0, done_v[0], 16'd0);
    @(negedge clk);
    start_v = 3'b001;
    @(negedge clk);
    acc = cyc; start_v = 3'b000;
    wait_done(0, 100, at);
    check("lat_after_rst", 0, 16'(at - acc), 16'd68);

    // Random traffic with occasional reset
    for (int i = 0; i < 4000; i++) begin
      start_v = {($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      for (int l = 0; l < 3; l++) begin addr_v[l] = 8'($urandom); wdata_v[l] = 8'($urandom); end
      rst_n = ($urandom_range(0, 999) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1; start_v = 3'b000;
    for (int i = 0; i < 9000 && (m_act[0] || m_act[1] || m_act[2]); i++) @(negedge clk);
    if (m_act[0] || m_act[1] || m_act[2]) begin
      checks++;
      errors++;
      $display("FAIL drain got busy want idle");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
